// File: rtl/procesador_pkg.sv
// Shared definitions for the vector processor pipeline: opcode encoding,
// instruction field positions and the fetch-stage state encoding.
package procesador_pkg;

  localparam int DEFAULT_PC_WIDTH    = 8;
  localparam int DEFAULT_INSTR_WIDTH = 16;

  localparam int OPCODE_WIDTH = 4;
  localparam int OPCODE_MSB   = 15;
  localparam int OPCODE_LSB   = 12;
  localparam int DEST_MSB     = 11;
  localparam int DEST_LSB     = 8;
  localparam int SRC_MSB      = 7;
  localparam int SRC_LSB      = 4;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_0001 = 4'b0001;
  localparam logic [3:0] OP_0010 = 4'b0010;
  localparam logic [3:0] OP_0011 = 4'b0011;
  localparam logic [3:0] OP_0100 = 4'b0100;
  localparam logic [3:0] OP_0101 = 4'b0101;
  localparam logic [3:0] OP_0110 = 4'b0110;
  localparam logic [3:0] OP_0111 = 4'b0111;
  localparam logic [3:0] OP_1000 = 4'b1000;
  localparam logic [3:0] OP_1001 = 4'b1001;
  localparam logic [3:0] OP_1010 = 4'b1010;
  localparam logic [3:0] OP_1011 = 4'b1011;
  localparam logic [3:0] OP_1100 = 4'b1100;
  localparam logic [3:0] OP_1101 = 4'b1101;
  localparam logic [3:0] OP_1110 = 4'b1110;
  localparam logic [3:0] OP_1111 = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/unidad_fetch_pc_counter.sv
// Program counter register: load has priority over increment, otherwise holds.
// Increment wraps naturally modulo 2^PC_WIDTH.
module pc_counter #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_value,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/unidad_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake and holds the issued instruction while downstream stalls.
module unidad_fetch
  import procesador_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   sel_pc,
  input  logic [PC_WIDTH-1:0]    pc_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [3:0]             opcode_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  output logic                   busy
);

  fetch_state_t state, next_state;
  logic [PC_WIDTH-1:0] pc;
  logic pc_load;
  logic pc_inc;
  logic capture;
  logic consume;

  pc_counter #(.PC_WIDTH(PC_WIDTH)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pc_load),
    .load_value (pc_target),
    .inc        (pc_inc),
    .pc         (pc)
  );

  assign imem_addr = pc;

  always_comb begin
    next_state = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    capture    = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          capture    = 1'b1;
          pc_inc     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        // sel_pc only matters in the cycle the instruction is actually consumed
        if (!stall) begin
          consume    = 1'b1;
          pc_load    = sel_pc;
          next_state = start ? FETCH : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      busy        <= 1'b0;
      instr       <= '0;
      opcode_out  <= OP_NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state    <= next_state;
      imem_req <= (next_state == FETCH);
      busy     <= (next_state != IDLE);
      if (capture) begin
        instr       <= imem_data;
        opcode_out  <= imem_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unidad_fetch.sv
// Directed bench for unidad_fetch: a per-cycle vector table plus a
// hand-written asynchronous reset sequence in the middle of a fetch.
module tb_unidad_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        sel_pc;
  logic [7:0]  pc_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [3:0]  opcode_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  unidad_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .sel_pc      (sel_pc),
    .pc_target   (pc_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .opcode_out  (opcode_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stall;
    logic        sel_pc;
    logic [7:0]  target;
    logic        ack;
    logic [15:0] data;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic [15:0] exp_instr;
    logic [7:0]  exp_ipc;
    logic        exp_valid;
    logic        exp_busy;
  } vec_t;

  localparam int NVEC = 32;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic st, logic sl, logic sp, logic [7:0] tg,
                              logic ak, logic [15:0] dt,
                              logic rq, logic [7:0] ad, logic [15:0] ins,
                              logic [7:0] ipc, logic vl, logic bz);
    vec_t v;
    v.start = st; v.stall = sl; v.sel_pc = sp; v.target = tg;
    v.ack = ak; v.data = dt;
    v.exp_req = rq; v.exp_addr = ad; v.exp_instr = ins;
    v.exp_ipc = ipc; v.exp_valid = vl; v.exp_busy = bz;
    return v;
  endfunction

  task automatic check_field(string name, logic [15:0] actual, logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_output(string tag, logic rq, logic [7:0] ad, logic [15:0] ins,
                              logic [7:0] ipc, logic vl, logic bz);
    check_field({tag, ".imem_req"},    {15'd0, imem_req},    {15'd0, rq});
    check_field({tag, ".imem_addr"},   {8'd0, imem_addr},    {8'd0, ad});
    check_field({tag, ".instr"},       instr,                ins);
    check_field({tag, ".opcode_out"},  {12'd0, opcode_out},  {12'd0, ins[15:12]});
    check_field({tag, ".instr_pc"},    {8'd0, instr_pc},     {8'd0, ipc});
    check_field({tag, ".instr_valid"}, {15'd0, instr_valid}, {15'd0, vl});
    check_field({tag, ".busy"},        {15'd0, busy},        {15'd0, bz});
  endtask

  task automatic apply_stimulus(vec_t v);
    start     = v.start;
    stall     = v.stall;
    sel_pc    = v.sel_pc;
    pc_target = v.target;
    imem_ack  = v.ack;
    imem_data = v.data;
  endtask

  // opcode_out must track the top nibble of instr on every cycle
  always @(negedge clk) begin
    n_checks++;
    if (opcode_out !== instr[15:12]) begin
      n_fail++;
      $display("[TB] FAIL opcode_slice: got %h, expected %h (t=%0t)", opcode_out, instr[15:12], $time);
    end
  end

  initial begin
    // inputs: start stall sel target ack data | expected after the edge
    vecs[0]  = mk(1,0,0,8'h00,0,16'h0000, 1,8'h00,16'h0000,8'h00,0,1);
    vecs[1]  = mk(1,0,0,8'h00,1,16'h1234, 0,8'h01,16'h1234,8'h00,1,1);
    vecs[2]  = mk(1,0,0,8'h00,0,16'h0000, 1,8'h01,16'h1234,8'h00,0,1);
    vecs[3]  = mk(1,0,0,8'h00,1,16'h2ABC, 0,8'h02,16'h2ABC,8'h01,1,1);
    vecs[4]  = mk(1,0,0,8'h00,0,16'h0000, 1,8'h02,16'h2ABC,8'h01,0,1);
    vecs[5]  = mk(1,0,0,8'h00,1,16'h3F00, 0,8'h03,16'h3F00,8'h02,1,1);
    vecs[6]  = mk(1,1,0,8'h00,0,16'h0000, 0,8'h03,16'h3F00,8'h02,1,1);
    vecs[7]  = mk(1,1,0,8'h00,1,16'hFFFF, 0,8'h03,16'h3F00,8'h02,1,1);
    vecs[8]  = mk(1,1,1,8'h20,0,16'h0000, 0,8'h03,16'h3F00,8'h02,1,1);
    vecs[9]  = mk(1,0,0,8'h00,0,16'h0000, 1,8'h03,16'h3F00,8'h02,0,1);
    vecs[10] = mk(1,0,0,8'h00,1,16'h4000, 0,8'h04,16'h4000,8'h03,1,1);
    vecs[11] = mk(1,0,0,8'h00,0,16'h0000, 1,8'h04,16'h4000,8'h03,0,1);
    vecs[12] = mk(1,0,0,8'h00,1,16'h5000, 0,8'h05,16'h5000,8'h04,1,1);
    vecs[13] = mk(1,0,0,8'h00,0,16'h0000, 1,8'h05,16'h5000,8'h04,0,1);
    vecs[14] = mk(1,0,0,8'h00,0,16'h0000, 1,8'h05,16'h5000,8'h04,0,1);
    vecs[15] = mk(1,0,0,8'h00,0,16'h0000, 1,8'h05,16'h5000,8'h04,0,1);
    vecs[16] = mk(1,0,0,8'h00,0,16'h0000, 1,8'h05,16'h5000,8'h04,0,1);
    vecs[17] = mk(1,0,0,8'h00,1,16'h6789, 0,8'h06,16'h6789,8'h05,1,1);
    vecs[18] = mk(1,0,1,8'h10,0,16'h0000, 1,8'h10,16'h6789,8'h05,0,1);
    vecs[19] = mk(1,0,0,8'h00,1,16'h7000, 0,8'h11,16'h7000,8'h10,1,1);
    vecs[20] = mk(1,0,1,8'h40,0,16'h0000, 1,8'h40,16'h7000,8'h10,0,1);
    vecs[21] = mk(1,0,0,8'h00,1,16'h8000, 0,8'h41,16'h8000,8'h40,1,1);
    vecs[22] = mk(1,1,1,8'hFF,0,16'h0000, 0,8'h41,16'h8000,8'h40,1,1);
    vecs[23] = mk(1,1,1,8'hFF,0,16'h0000, 0,8'h41,16'h8000,8'h40,1,1);
    vecs[24] = mk(1,0,1,8'hFF,0,16'h0000, 1,8'hFF,16'h8000,8'h40,0,1);
    vecs[25] = mk(1,0,0,8'h00,1,16'h9000, 0,8'h00,16'h9000,8'hFF,1,1);
    vecs[26] = mk(0,0,0,8'h00,0,16'h0000, 0,8'h00,16'h9000,8'hFF,0,0);
    vecs[27] = mk(0,1,0,8'h00,1,16'h1111, 0,8'h00,16'h9000,8'hFF,0,0);
    vecs[28] = mk(1,0,0,8'h00,0,16'h0000, 1,8'h00,16'h9000,8'hFF,0,1);
    vecs[29] = mk(0,0,0,8'h00,0,16'h0000, 1,8'h00,16'h9000,8'hFF,0,1);
    vecs[30] = mk(0,0,0,8'h00,1,16'hA000, 0,8'h01,16'hA000,8'h00,1,1);
    vecs[31] = mk(1,0,1,8'h07,0,16'h0000, 1,8'h07,16'hA000,8'h00,0,1);

    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; sel_pc = 1'b0; pc_target = 8'h00;
    imem_ack = 1'b0; imem_data = 16'h0000;
    #2;
    check_output("reset", 0, 8'h00, 16'h0000, 8'h00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle", 0, 8'h00, 16'h0000, 8'h00, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      check_output($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                   vecs[i].exp_instr, vecs[i].exp_ipc, vecs[i].exp_valid, vecs[i].exp_busy);
    end

    // In FETCH at address 7: pull reset between edges, req must drop at once
    start = 1'b0; sel_pc = 1'b0; imem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst", 0, 8'h00, 16'h0000, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_data = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    check_output("late_ack", 0, 8'h00, 16'h0000, 8'h00, 0, 0);
    imem_ack = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("restart", 1, 8'h00, 16'h0000, 8'h00, 0, 1);
    imem_ack = 1'b1; imem_data = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    check_output("refetch", 0, 8'h01, 16'h1234, 8'h00, 1, 1);
    imem_ack = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("final_idle", 0, 8'h01, 16'h1234, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
